// File: rtl/ibus_arbiter_if.sv
// Bus bundle between the two instruction-memory requesters, the arbiter and the memory port.
// The arbiter uses the slave view; the environment (requesters plus memory) uses the master view.
interface ibus_arbiter_if;
  logic        m0_rd_en;
  logic [31:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rd_valid;
  logic [31:0] m0_rd_data;

  logic        m1_rd_en;
  logic        m1_wr_en;
  logic [31:0] m1_addr;
  logic [31:0] m1_wr_data;
  logic [3:0]  m1_wr_strb;
  logic        m1_gnt;
  logic        m1_rd_valid;
  logic [31:0] m1_rd_data;

  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic [31:0] mem_rd_data;

  modport slave (
    input  m0_rd_en, m0_addr,
    output m0_gnt, m0_rd_valid, m0_rd_data,
    input  m1_rd_en, m1_wr_en, m1_addr, m1_wr_data, m1_wr_strb,
    output m1_gnt, m1_rd_valid, m1_rd_data,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_strb,
    input  mem_rd_data
  );

  modport master (
    output m0_rd_en, m0_addr,
    input  m0_gnt, m0_rd_valid, m0_rd_data,
    output m1_rd_en, m1_wr_en, m1_addr, m1_wr_data, m1_wr_strb,
    input  m1_gnt, m1_rd_valid, m1_rd_data,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_wr_strb,
    output mem_rd_data
  );
endinterface

// File: rtl/ibus_arbiter.sv
// Two-port instruction memory arbiter: fixed priority to fetch with a starvation guard for
// the loader port, and an owner-tag pipe that routes read data back to the requesting port.
module ibus_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ibus_arbiter_if.slave   bus
);

  localparam int             CW       = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]  WAIT_MAX = CW'(MAX_WAIT);
  localparam logic           OWN_M0   = 1'b0;
  localparam logic           OWN_M1   = 1'b1;

  logic [CW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [RD_LATENCY-1:0]  vld_q;
  logic [RD_LATENCY-1:0]  own_q;
  logic                   m1_req, gnt0, gnt1, rd_issue, rd_owner;
  logic                   resp_vld;

  always_comb begin
    m1_req = bus.m1_rd_en | bus.m1_wr_en;
    // Grants are gated by rst_n so nothing reaches memory while reset is held.
    gnt1   = rst_n & m1_req & ((wait_cnt_q == WAIT_MAX) | ~bus.m0_rd_en);
    gnt0   = rst_n & bus.m0_rd_en & ~gnt1;

    wait_cnt_d = wait_cnt_q;
    if (!m1_req || gnt1)
      wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX)
      wait_cnt_d = wait_cnt_q + CW'(1);

    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_strb = '0;
    rd_issue        = 1'b0;
    rd_owner        = OWN_M0;
    if (gnt0) begin
      bus.mem_rd_en = 1'b1;
      bus.mem_addr  = bus.m0_addr;
      rd_issue      = 1'b1;
    end else if (gnt1) begin
      // A simultaneous read+write request is a plain write with no response.
      bus.mem_rd_en   = bus.m1_rd_en & ~bus.m1_wr_en;
      bus.mem_wr_en   = bus.m1_wr_en;
      bus.mem_addr    = bus.m1_addr;
      bus.mem_wr_data = bus.m1_wr_data;
      bus.mem_wr_strb = bus.m1_wr_strb;
      rd_issue        = bus.m1_rd_en & ~bus.m1_wr_en;
      rd_owner        = OWN_M1;
    end

    bus.m0_gnt = gnt0;
    bus.m1_gnt = gnt1;

    resp_vld        = vld_q[RD_LATENCY-1];
    bus.m0_rd_valid = resp_vld & (own_q[RD_LATENCY-1] == OWN_M0);
    bus.m1_rd_valid = resp_vld & (own_q[RD_LATENCY-1] == OWN_M1);
    bus.m0_rd_data  = bus.m0_rd_valid ? bus.mem_rd_data : '0;
    bus.m1_rd_data  = bus.m1_rd_valid ? bus.mem_rd_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      vld_q      <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      vld_q[0]   <= rd_issue;
      for (int i = 1; i < RD_LATENCY; i++)
        vld_q[i] <= vld_q[i-1];
    end
  end

  // Owner tags are only meaningful alongside a set valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    own_q[0] <= rd_owner;
    for (int i = 1; i < RD_LATENCY; i++)
      own_q[i] <= own_q[i-1];
  end

endmodule

// File: tb/tb_ibus_arbiter.sv
// Directed bench for ibus_arbiter with a behavioural memory, a grant/response model and literal checks.
module tb_ibus_arbiter;

  localparam int L  = 2;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  ibus_arbiter_if bus ();

  ibus_arbiter #(.RD_LATENCY(L), .MAX_WAIT(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural memory: word array, byte strobes, fixed read latency.
  logic [31:0] mem_arr [0:255];
  logic [31:0] rdp [0:L-1] = '{default: 32'h0};
  logic        mem_ready = 1'b0;

  assign bus.mem_rd_data = rdp[L-1];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'hA000_0000 | i;
      mem_ready <= 1'b1;
    end else begin
      if (bus.mem_rd_en) rdp[0] <= mem_arr[bus.mem_addr[7:0]];
      for (int i = 1; i < L; i++) rdp[i] <= rdp[i-1];
      if (bus.mem_wr_en)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wr_strb[b])
            mem_arr[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Model: arbitration rules, starvation counter and a queue of responses due at a given cycle.
  typedef struct {
    int          due;
    bit          port;
    logic [31:0] data;
  } resp_t;
  resp_t q[$];
  int    mwait = 0;

  always @(negedge clk) begin : model_cmp
    logic        m1req, g0, g1, erd, ewr, rv0, rv1;
    logic [31:0] ea, ed, rd0, rd1;
    logic [3:0]  es;
    if (!rst_n) begin
      chk("rst_m0_gnt", bus.m0_gnt, 0);
      chk("rst_m1_gnt", bus.m1_gnt, 0);
      chk("rst_mem_rd_en", bus.mem_rd_en, 0);
      chk("rst_mem_wr_en", bus.mem_wr_en, 0);
      chk("rst_m0_rd_valid", bus.m0_rd_valid, 0);
      chk("rst_m1_rd_valid", bus.m1_rd_valid, 0);
      chk("rst_m0_rd_data", bus.m0_rd_data, 0);
      chk("rst_m1_rd_data", bus.m1_rd_data, 0);
      mwait = 0;
      q.delete();
    end else begin
      m1req = bus.m1_rd_en | bus.m1_wr_en;
      g1 = m1req && (mwait == MW || !bus.m0_rd_en);
      g0 = bus.m0_rd_en && !g1;
      erd = 0; ewr = 0; ea = 0; ed = 0; es = 0;
      if (g0) begin
        erd = 1; ea = bus.m0_addr;
      end else if (g1) begin
        ewr = bus.m1_wr_en; erd = bus.m1_rd_en && !bus.m1_wr_en;
        ea = bus.m1_addr; ed = bus.m1_wr_data; es = bus.m1_wr_strb;
      end
      rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].port) begin rv1 = 1; rd1 = q[0].data; end
        else begin rv0 = 1; rd0 = q[0].data; end
        void'(q.pop_front());
      end
      chk("m0_gnt", bus.m0_gnt, g0);
      chk("m1_gnt", bus.m1_gnt, g1);
      chk("mem_rd_en", bus.mem_rd_en, erd);
      chk("mem_wr_en", bus.mem_wr_en, ewr);
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_wr_data", bus.mem_wr_data, ed);
      chk("mem_wr_strb", bus.mem_wr_strb, es);
      chk("m0_rd_valid", bus.m0_rd_valid, rv0);
      chk("m1_rd_valid", bus.m1_rd_valid, rv1);
      chk("m0_rd_data", bus.m0_rd_data, rd0);
      chk("m1_rd_data", bus.m1_rd_data, rd1);
      if (erd) q.push_back('{due: cyc + L, port: g1, data: mem_arr[ea[7:0]]});
      if (!m1req || g1) mwait = 0;
      else if (mwait < MW) mwait = mwait + 1;
    end
    cyc++;
  end

  task automatic drv(input logic r0, input logic [31:0] a0, input logic r1, input logic w1,
                     input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    bus.m0_rd_en   = r0;
    bus.m0_addr    = a0;
    bus.m1_rd_en   = r1;
    bus.m1_wr_en   = w1;
    bus.m1_addr    = a1;
    bus.m1_wr_data = d1;
    bus.m1_wr_strb = s1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: back-to-back fetch reads of addr 0,1,2
    for (int i = 0; i < 3 + L; i++) begin
      if (i < 3) drv(1, i, 0, 0, 0, 0, 0); else idle();
      @(negedge clk);
      if (i < 3) chk("t1_m0_gnt", bus.m0_gnt, 1);
      if (i >= L) begin
        chk("t1_m0_rd_valid", bus.m0_rd_valid, 1);
        chk("t1_m0_rd_data", bus.m0_rd_data, 32'hA000_0000 + (i - L));
      end
      nxt();
    end
    repeat (2) nxt();

    // 2: both ports read continuously; port 1 forced every fifth cycle
    for (int i = 0; i < 10; i++) begin
      drv(1, 32'h40, 1, 0, 32'h41, 0, 0);
      @(negedge clk);
      chk("t2_m1_gnt", bus.m1_gnt, (i == 4 || i == 9));
      chk("t2_m0_gnt", bus.m0_gnt, !(i == 4 || i == 9));
      nxt();
    end
    idle();
    repeat (L + 1) nxt();

    // 3: port-1 partial write, then read it back
    drv(0, 0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
    @(negedge clk);
    chk("t3_m1_gnt", bus.m1_gnt, 1);
    chk("t3_mem_wr_en", bus.mem_wr_en, 1);
    chk("t3_mem_wr_strb", bus.mem_wr_strb, 4'b0011);
    chk("t3_mem_addr", bus.mem_addr, 32'h10);
    chk("t3_mem_wr_data", bus.mem_wr_data, 32'hDEAD_BEEF);
    nxt();
    idle();
    for (int i = 0; i < L + 1; i++) begin
      @(negedge clk);
      chk("t3_no_rd_valid", {bus.m0_rd_valid, bus.m1_rd_valid}, 0);
      nxt();
    end
    drv(0, 0, 1, 0, 32'h10, 0, 0);
    nxt();
    idle();
    repeat (L - 1) nxt();
    @(negedge clk);
    chk("t3_readback_valid", bus.m1_rd_valid, 1);
    chk("t3_readback_data", bus.m1_rd_data, 32'hA000_BEEF);
    nxt();

    // 4: read and write together act as a write only
    drv(0, 0, 1, 1, 32'h20, 32'h1234_5678, 4'hF);
    @(negedge clk);
    chk("t4_mem_rd_en", bus.mem_rd_en, 0);
    chk("t4_mem_wr_en", bus.mem_wr_en, 1);
    nxt();
    idle();
    for (int i = 0; i < L + 1; i++) begin
      @(negedge clk);
      chk("t4_m1_rd_valid", bus.m1_rd_valid, 0);
      nxt();
    end

    // 5: reset pulse while a fetch read is in flight
    drv(1, 32'h3, 0, 0, 0, 0, 0);
    nxt();
    drv(1, 32'h5, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_m0_gnt", bus.m0_gnt, 0);
    chk("t5_rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("t5_rst_m0_rd_data", bus.m0_rd_data, 0);
    nxt();
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      chk("t5_no_m0_rd_valid", bus.m0_rd_valid, 0);
      nxt();
    end

    // 6: alternating port reads, responses routed to their owners only
    for (int i = 0; i < 6 + L; i++) begin
      if (i >= 6) idle();
      else if (i % 2 == 0) drv(1, 32'h60 + i, 0, 0, 0, 0, 0);
      else drv(0, 0, 1, 0, 32'h60 + i, 0, 0);
      @(negedge clk);
      if (i >= L) begin
        if ((i - L) % 2 == 0) begin
          chk("t6_m0_rd_data", bus.m0_rd_data, 32'hA000_0060 + (i - L));
          chk("t6_m1_rd_data_zero", bus.m1_rd_data, 0);
        end else begin
          chk("t6_m1_rd_data", bus.m1_rd_data, 32'hA000_0060 + (i - L));
          chk("t6_m0_rd_data_zero", bus.m0_rd_data, 0);
        end
      end
      nxt();
    end
    repeat (2) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
